cpu_step_ctrl: RTL and testbench

CPU_STEP_CTRL -- requirements
Module: cpu_step_ctrl

---
 rtl/cpu_step_ctrl.sv | 178 +++++++++++++++++
 tb/tb_cpu_step_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_step_ctrl.sv
// Single-step / free-run clock-enable controller for a soft CPU (HALT, STEP, RUN).
// Define CPU_STEP_COUNT_EN to include the step_count counter; otherwise step_count reads 0.
module cpu_step_ctrl #(
   parameter int DB_CYCLES = 500000,
   parameter int RUN_DIV   = 50000000,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run_sw,
   input  logic             step_btn,
   input  logic             halt_req,
   output logic             cpu_en,
   output logic             running,
   output logic [CNT_W-1:0] step_count
);

   localparam int DB_W  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

   typedef enum logic [1:0] {
      S_HALT = 2'd0,
      S_STEP = 2'd1,
      S_RUN  = 2'd2
   } state_t;

   // Index 0 is run_sw, index 1 is step_btn.
   logic [1:0] raw_in;
   logic [1:0] db_lvl;

   assign raw_in = {step_btn, run_sw};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_in
         logic            sync1_q;
         logic            sync2_q;
         logic            lvl_q;
         logic [DB_W-1:0] cnt_q;

         // Level flips only after DB_CYCLES consecutive cycles of disagreement.
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               sync1_q <= 1'b0;
               sync2_q <= 1'b0;
               lvl_q   <= 1'b0;
               cnt_q   <= '0;
            end else begin
               sync1_q <= raw_in[gi];
               sync2_q <= sync1_q;
               if (sync2_q != lvl_q) begin
                  if (cnt_q == DB_LAST) begin
                     lvl_q <= sync2_q;
                     cnt_q <= '0;
                  end else begin
                     cnt_q <= cnt_q + DB_W'(1);
                  end
               end else begin
                  cnt_q <= '0;
               end
            end
         end

         assign db_lvl[gi] = lvl_q;
      end
   endgenerate

   logic run_db;
   logic step_db;
   logic step_prev_q;
   logic step_evt;

   assign run_db   = db_lvl[0];
   assign step_db  = db_lvl[1];
   assign step_evt = step_db & ~step_prev_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         step_prev_q <= 1'b0;
      end else begin
         step_prev_q <= step_db;
      end
   end

   state_t           state_q;
   state_t           state_d;
   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] div_d;
   logic             lock_q;
   logic             lock_d;
   logic             cpu_en_q;
   logic             cpu_en_d;
   logic             running_q;
   logic             running_d;
   logic             run_stay;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_HALT;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_HALT: begin
            if (step_evt) begin
               state_d = S_STEP;
            end else if (run_db && !lock_q && !halt_req) begin
               state_d = S_RUN;
            end
         end
         S_STEP: state_d = S_HALT;
         S_RUN: begin
            if (!run_db || halt_req) begin
               state_d = S_HALT;
            end
         end
         default: state_d = S_HALT;
      endcase
   end

   // A RUN pulse is launched only on an edge that stays in RUN, so a halt on the
   // terminal count suppresses it. RUN_DIV must be at least 2.
   always_comb begin
      run_stay  = (state_q == S_RUN) && (state_d == S_RUN);
      div_d     = '0;
      if (run_stay) begin
         div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
      end
      cpu_en_d  = (state_d == S_STEP) || (run_stay && (div_q == DIV_LAST));
      running_d = (state_d == S_RUN);
      lock_d    = lock_q;
      if (halt_req) begin
         lock_d = 1'b1;
      end else if (!run_db) begin
         lock_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_q     <= '0;
         lock_q    <= 1'b0;
         cpu_en_q  <= 1'b0;
         running_q <= 1'b0;
      end else begin
         div_q     <= div_d;
         lock_q    <= lock_d;
         cpu_en_q  <= cpu_en_d;
         running_q <= running_d;
      end
   end

   assign cpu_en  = cpu_en_q;
   assign running = running_q;

`ifdef CPU_STEP_COUNT_EN
   logic [CNT_W-1:0] count_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else if (cpu_en_q) begin
         count_q <= count_q + CNT_W'(1);
      end
   end

   assign step_count = count_q;
`else
   assign step_count = '0;
`endif

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Randomized scoreboard bench for cpu_step_ctrl with a cycle-level behavioural model.
module tb_cpu_step_ctrl;

   localparam int DB  = 4;
   localparam int DIV = 3;
   localparam int CW  = 4;

   localparam int M_HALT = 0;
   localparam int M_STEP = 1;
   localparam int M_RUN  = 2;

   logic          clk      = 1'b0;
   logic          reset    = 1'b0;
   logic          run_sw   = 1'b0;
   logic          step_btn = 1'b0;
   logic          halt_req = 1'b0;
   logic          cpu_en;
   logic          running;
   logic [CW-1:0] step_count;

   always #5 clk = ~clk;

   cpu_step_ctrl #(
      .DB_CYCLES(DB),
      .RUN_DIV  (DIV),
      .CNT_W    (CW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .run_sw    (run_sw),
      .step_btn  (step_btn),
      .halt_req  (halt_req),
      .cpu_en    (cpu_en),
      .running   (running),
      .step_count(step_count)
   );

   typedef struct packed {
      logic          en;
      logic          run;
      logic [CW-1:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   vectors     = 0;
   int   miscompares = 0;
   int   obs_pulses  = 0;

   // Reference model state: sync pipeline, consecutive-disagreement counts, mode.
   int m_s1[2];
   int m_s2[2];
   int m_lvl[2];
   int m_diff[2];
   int m_prev;
   int m_mode;
   int m_run_cycles;
   int m_lock;
   int m_en;
   int m_count;

   function automatic void model_reset();
      for (int i = 0; i < 2; i++) begin
         m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_diff[i] = 0;
      end
      m_prev = 0; m_mode = M_HALT; m_run_cycles = 0;
      m_lock = 0; m_en = 0; m_count = 0;
   endfunction

   function automatic void model_edge(input int r_run, input int r_step, input int r_halt);
      int evt;
      int nxt;
      int new_en;
      evt = (m_lvl[1] == 1 && m_prev == 0) ? 1 : 0;
      nxt = M_HALT;
      if (m_mode == M_HALT) begin
         if (evt != 0) nxt = M_STEP;
         else if (m_lvl[0] == 1 && m_lock == 0 && r_halt == 0) nxt = M_RUN;
      end else if (m_mode == M_RUN) begin
         nxt = (m_lvl[0] == 1 && r_halt == 0) ? M_RUN : M_HALT;
      end
      new_en = (nxt == M_STEP) ? 1 : 0;
      if (m_mode == M_RUN && nxt == M_RUN) begin
         if (m_run_cycles % DIV == DIV - 1) new_en = 1;
         m_run_cycles++;
      end else begin
         m_run_cycles = 0;
      end
      m_count = (m_count + m_en) % (1 << CW);
      m_en    = new_en;
      if (r_halt != 0) m_lock = 1;
      else if (m_lvl[0] == 0) m_lock = 0;
      m_prev = m_lvl[1];
      for (int i = 0; i < 2; i++) begin
         if (m_s2[i] != m_lvl[i]) begin
            m_diff[i]++;
            if (m_diff[i] == DB) begin
               m_lvl[i]  = m_s2[i];
               m_diff[i] = 0;
            end
         end else begin
            m_diff[i] = 0;
         end
         m_s2[i] = m_s1[i];
      end
      m_s1[0] = r_run;
      m_s1[1] = r_step;
      m_mode  = nxt;
   endfunction

   task automatic check(input string name, input int got, input int want);
      vectors++;
      if (got != want) begin
         miscompares++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   // One clock of stimulus: drive at negedge, advance the model, queue the expectation.
   task automatic cycle(input logic rst, input logic r_run, input logic r_step, input logic r_halt);
      exp_t e;
      logic was;
      @(negedge clk);
      was      = reset;
      reset    = rst;
      run_sw   = r_run;
      step_btn = r_step;
      halt_req = r_halt;
      if (!rst) model_reset();
      else model_edge(int'(r_run), int'(r_step), int'(r_halt));
      e.en  = (m_en != 0);
      e.run = (m_mode == M_RUN);
`ifdef CPU_STEP_COUNT_EN
      e.cnt = CW'(m_count);
`else
      e.cnt = '0;
`endif
      exp_q.push_back(e);
      if (was && !rst) begin
         #1;
         check("reset_immediate", int'({cpu_en, running, step_count}), 0);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            vectors++;
            if (cpu_en === 1'b1) obs_pulses++;
            if ({cpu_en, running, step_count} !== mon_e) begin
               miscompares++;
               $display("FAIL vec%0d: cpu_en/running/step_count got %b/%b/%0d want %b/%b/%0d",
                        vectors, cpu_en, running, step_count, mon_e.en, mon_e.run, mon_e.cnt);
            end
         end
      end
   end

   initial begin
      int p0;
      int guard;
      logic r_run;
      logic r_step;
      model_reset();
      repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0);
      repeat (5) cycle(1'b1, 1'b0, 1'b0, 1'b0);

      // Long press with run_sw low: exactly one pulse.
      p0 = obs_pulses;
      repeat (20) cycle(1'b1, 1'b0, 1'b1, 1'b0);
      repeat (12) cycle(1'b1, 1'b0, 1'b0, 1'b0);
      check("step_hold_pulses", obs_pulses - p0, 1);

      // Short glitch never passes the debouncer.
      p0 = obs_pulses;
      repeat (3) cycle(1'b1, 1'b0, 1'b1, 1'b0);
      repeat (12) cycle(1'b1, 1'b0, 1'b0, 1'b0);
      check("glitch_pulses", obs_pulses - p0, 0);

      // Random-length presses.
      repeat (6) begin
         repeat ($urandom_range(1, 8)) cycle(1'b1, 1'b0, 1'b1, 1'b0);
         repeat ($urandom_range(1, 8)) cycle(1'b1, 1'b0, 1'b0, 1'b0);
      end

      // Free run long enough to wrap step_count, with step noise that RUN ignores.
      repeat (70) cycle(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b0);

      // Halt exactly on the divider terminal cycle.
      guard = 0;
      while (guard < 10 && !(m_mode == M_RUN && m_run_cycles % DIV == DIV - 1)) begin
         cycle(1'b1, 1'b1, 1'b0, 1'b0);
         guard++;
      end
      check("halt_align_found", (guard < 10) ? 1 : 0, 1);
      p0 = obs_pulses;
      cycle(1'b1, 1'b1, 1'b0, 1'b1);
      repeat (20) cycle(1'b1, 1'b1, 1'b0, 1'b0);
      check("locked_pulses", obs_pulses - p0, 0);
      check("locked_running", int'(running), 0);
      repeat (8) cycle(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (20) cycle(1'b1, 1'b1, 1'b0, 1'b0);
      check("rerun_running", int'(running), 1);

      // Reset between pulses in RUN.
      guard = 0;
      while (guard < 10 && !(m_mode == M_RUN && m_run_cycles % DIV == 0)) begin
         cycle(1'b1, 1'b1, 1'b0, 1'b0);
         guard++;
      end
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      repeat (3) cycle(1'b0, 1'b1, 1'b0, 1'b0);
      p0 = obs_pulses;
      repeat (6) cycle(1'b1, 1'b1, 1'b0, 1'b0);
      check("post_reset_pulses", obs_pulses - p0, 0);
      repeat (15) cycle(1'b1, 1'b1, 1'b0, 1'b0);

      // Randomized mix of switch, button, halt and reset activity.
      r_run  = 1'b1;
      r_step = 1'b0;
      repeat (400) begin
         if ($urandom_range(0, 39) == 0) r_run = ~r_run;
         if ($urandom_range(0, 5) == 0) r_step = ~r_step;
         cycle(($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1, r_run, r_step,
               ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0);
      end

      repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
